// File: rtl/simple_processor_pkg.sv
// simple_processor_pkg: shared width, opcode constants and FSM state type
// for the 9-bit multi-cycle bus processor.
package simple_processor_pkg;
  localparam int W = 9;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MVI = 3'b011;
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
endpackage

// File: rtl/simple_processor_top_regn.sv
// regn: W-bit load-enable register with asynchronous active-low clear.
module regn
  import simple_processor_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/simple_processor_top.sv
// simple_processor_top: 9-bit multi-cycle processor; control FSM, bus mux and
// add/sub unit around eight general registers plus IR, A and G.
module simple_processor_top
  import simple_processor_pkg::*;
(
  input  logic         Run,
  input  logic         Resetn,
  input  logic         Clock,
  input  logic [W-1:0] DIN,
  output logic [W-1:0] Bus,
  output logic         Done
);
  state_t       state_q, state_d;
  logic [W-1:0] r_q [8];
  logic [7:0]   r_en;
  logic [W-1:0] ir_q, a_q, g_q, g_d;
  logic         ir_en, a_en, g_en;
  logic [2:0]   op, rx, ry;
  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];
  assign g_d = (op == OP_SUB) ? a_q - Bus : a_q + Bus;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state_q <= T0;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    Bus     = DIN;
    Done    = 1'b0;
    ir_en   = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    r_en    = '0;
    case (state_q)
      T0: begin
        ir_en   = Run;
        state_d = Run ? T1 : T0;
      end
      T1: begin
        state_d = T0;
        case (op)
          OP_MV: begin
            Bus      = r_q[ry];
            r_en[rx] = 1'b1;
            Done     = 1'b1;
          end
          OP_MVI: begin
            r_en[rx] = 1'b1;
            Done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Bus     = r_q[rx];
            a_en    = 1'b1;
            state_d = T2;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        Bus     = r_q[ry];
        g_en    = 1'b1;
        state_d = T3;
      end
      T3: begin
        Bus      = g_q;
        r_en[rx] = 1'b1;
        Done     = 1'b1;
        state_d  = T0;
      end
      default: state_d = T0;
    endcase
  end
  for (genvar i = 0; i < 8; i++) begin : g_r
    regn u_r (.clk(Clock), .rst_n(Resetn), .en(r_en[i]), .d(Bus), .q(r_q[i]));
  end
  regn u_ir (.clk(Clock), .rst_n(Resetn), .en(ir_en), .d(DIN), .q(ir_q));
  regn u_a  (.clk(Clock), .rst_n(Resetn), .en(a_en),  .d(Bus), .q(a_q));
  regn u_g  (.clk(Clock), .rst_n(Resetn), .en(g_en),  .d(g_d), .q(g_q));
endmodule

// File: tb/tb_simple_processor_top.sv
// tb_simple_processor_top: directed and random instruction streams checked
// against an architectural register-file model.
module tb_simple_processor_top;
  import simple_processor_pkg::*;
  logic         run, resetn, clock;
  logic [W-1:0] din, bus;
  logic         done;
  int           n_cmp, n_err;
  logic [W-1:0] m [8];
  simple_processor_top dut (
    .Run(run), .Resetn(resetn), .Clock(clock), .DIN(din), .Bus(bus), .Done(done)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Called at a negedge with the processor idle; returns at a negedge idle.
  task automatic exec(input logic [8:0] ins, input logic [8:0] imm);
    logic [2:0] op, rx, ry;
    logic [8:0] res;
    int lat, cyc;
    bit wr;
    op  = ins[8:6];
    rx  = ins[5:3];
    ry  = ins[2:0];
    lat = (op == OP_ADD || op == OP_SUB) ? 3 : 1;
    wr  = op <= 3'd3;
    res = op == OP_MV ? m[ry] : op == OP_ADD ? 9'(m[rx] + m[ry]) :
          op == OP_SUB ? 9'(m[rx] - m[ry]) : imm;
    din = ins;
    run = 1'b1;
    #1;
    check("t0_bus", bus, ins);
    check("t0_done", done, 0);
    @(negedge clock);
    cyc = 1;
    din = (op == OP_MVI) ? imm : 9'($urandom);
    run = 1'($urandom);
    #1;
    while (!done && cyc < 6) begin
      @(negedge clock);
      cyc++;
      din = 9'($urandom);
      run = 1'($urandom);
      #1;
    end
    check("latency", cyc, lat);
    check("done_bus", bus, wr ? int'(res) : int'(din));
    @(negedge clock);
    run = 1'b0;
    #1;
    check("post_done", done, 0);
    if (wr) m[rx] = res;
  endtask
  task automatic read_reg(input int i, output logic [8:0] v);
    din = {3'b000, 3'(i), 3'(i)};
    run = 1'b1;
    @(negedge clock);
    #1;
    v = bus;
    @(negedge clock);
    run = 1'b0;
  endtask
  task automatic dump(input string tag);
    logic [8:0] v;
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      check(tag, v, m[i]);
    end
  endtask
  initial begin
    logic [8:0] v;
    n_cmp  = 0;
    n_err  = 0;
    run    = 1'b0;
    resetn = 1'b0;
    din    = 9'h0a5;
    for (int i = 0; i < 8; i++) m[i] = '0;
    @(negedge clock);
    #1;
    check("rst_done", done, 0);
    check("rst_bus", bus, 9'h0a5);
    resetn = 1'b1;
    @(negedge clock);
    dump("rst_reg");
    exec(9'b000_011_100, 9'd0);
    exec(9'b011_000_001, 9'b111_001_111);
    exec(9'b011_010_001, 9'b111_111_111);
    exec(9'b011_001_001, 9'b101_010_101);
    read_reg(0, v); check("mvi_r0", v, 463);
    read_reg(2, v); check("mvi_r2", v, 511);
    read_reg(1, v); check("mvi_r1", v, 341);
    exec(9'b000_101_010, 9'd0);
    read_reg(5, v); check("mv_r5", v, 511);
    exec(9'b001_000_001, 9'd0);
    read_reg(0, v); check("add_r0", v, 292);
    exec(9'b010_001_010, 9'd0);
    read_reg(1, v); check("sub_r1", v, 342);
    exec(9'b001_011_011, 9'd0);
    exec(9'b111_000_001, 9'd0);
    dump("dir_reg");
    din = 9'b001_101_000;
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("mid_rst_done", done, 0);
    check("mid_rst_bus", bus, din);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      run = 1'b1;
      #1;
      check("rst_hold_done", done, 0);
    end
    run    = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) m[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      din = 9'($urandom);
      #1;
      check("idle_done", done, 0);
      check("idle_bus", bus, din);
    end
    dump("post_rst_reg");
    for (int n = 0; n < 80; n++) begin
      exec(9'($urandom), 9'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        din = 9'($urandom);
        @(negedge clock);
        #1;
        check("rand_idle", done, 0);
      end
      if (n % 20 == 19) dump("rand_reg");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
